agu_arbiter: RTL
================

AGU_ARBITER -- requirements
Module: agu_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, the number of reservation stations sharing the AGU.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 4, the maximum number of AGU operations outstanding at once.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port flush, input, 1 bit: pipeline flush.
REQ-006 SHALL have port req_rdy, input, [NUM_REQ] bits: requester i holds an operand-ready entry awaiting address generation.
REQ-007 SHALL have port req_pkt, input, instruction_t [NUM_REQ]: the entry offered by each requester.
REQ-008 SHALL have port req_grant, output, [NUM_REQ] bits: one-hot pulse when requester i's entry is accepted this cycle.
REQ-009 SHALL have port agu_rdy, input, 1 bit: the AGU can accept an operation this cycle.
REQ-010 SHALL have port agu_valid, output, 1 bit: an issue to the AGU this cycle.
REQ-011 SHALL have port agu_pkt, output, instruction_t: the granted entry.
REQ-012 SHALL have port agu_port, input, writeback_packet_t: the AGU result, valid when is_valid=1.
REQ-013 SHALL have port resp_valid, output, [NUM_REQ] bits: one-hot pulse routing the result to its owner.
REQ-014 SHALL have port resp_pkt, output, writeback_packet_t: agu_port passed through combinationally.
REQ-015 SHALL have port rob_head, input, TAG_WIDTH bits: the oldest ROB tag.
REQ-016 SHALL have port inflight_cnt, output, clog2(MAX_INFLIGHT+1) bits: the count of outstanding operations.
REQ-017 SHALL have port tag_err, output, 1 bit: sticky protocol-error flag.

Function
REQ-018 Issue SHALL be enabled only when state is not DRAIN, flush=0, agu_rdy=1, inflight_cnt<MAX_INFLIGHT, and some req_rdy=1.
REQ-019 Grant SHALL be combinational, with zero-cycle latency; agu_valid SHALL equal OR(req_grant), and agu_pkt SHALL equal req_pkt of the granted requester, else '0.
REQ-020 Round-robin mode SHALL search from rr_ptr upward with wrap; after each grant, rr_ptr becomes (granted index+1) mod NUM_REQ.
REQ-021 An owner FIFO of depth MAX_INFLIGHT SHALL push {requester index, dest_tag, squashed=0} on each issue; the AGU returns results in order.
REQ-022 On agu_port.is_valid=1, the FIFO head SHALL pop.
  - If the head is not squashed and dest_tag matches, resp_valid[owner] SHALL pulse in the same cycle.
  - If the dest_tag mismatches, tag_err SHALL be set and no resp_valid SHALL pulse.
REQ-023 A result arriving while the FIFO is empty SHALL set tag_err and be ignored; the count SHALL not underflow.
REQ-024 inflight_cnt SHALL update as follows: +1 on issue, -1 on pop, unchanged when both occur in the same cycle.
REQ-025 FSM states SHALL be IDLE (cnt=0), BUSY (cnt>0), and DRAIN.
  - IDLE->BUSY on issue.
  - BUSY->IDLE when the next cnt is 0.
  - Any state->DRAIN on flush when the next cnt is greater than 0, else ->IDLE.
  - DRAIN->IDLE when the next cnt is 0.
REQ-026 Flush SHALL mark all FIFO entries squashed; a result popped in the flush cycle SHALL still be suppressed; no grant SHALL occur in the flush cycle.
REQ-027 In DRAIN, pops SHALL proceed without resp_valid; a repeated flush SHALL keep the state DRAIN.
REQ-028 At inflight_cnt=MAX_INFLIGHT, no grant SHALL occur even if a pop occurs in the same cycle.

Reset
REQ-029 On rst, the following SHALL be reset:
  - state=IDLE, rr_ptr=0, FIFO empty, inflight_cnt=0, tag_err=0.
  - req_grant=0, agu_valid=0, resp_valid=0.
REQ-030 rst mid-operation SHALL discard all outstanding ownership; later stray results SHALL follow REQ-023.

Configuration
REQ-031 With macro AGU_ARB_AGE_PRIO_EN defined, arbitration SHALL grant the ready requester whose req_pkt.dest_tag-rob_head (modulo TAG_WIDTH) is smallest; ties go to the lowest index; rr_ptr is unused.
REQ-032 Without AGU_ARB_AGE_PRIO_EN, arbitration SHALL be pure round-robin per REQ-020.

Verification
REQ-033 Scenario: both req_rdy=1 for 4 cycles, agu_rdy=1, no results -> grants 0,1,0,1; the fifth cycle gives no grant with inflight_cnt=4.
REQ-034 Scenario: issue tags 5 (req0) and 9 (req1), then return results 5 and 9 -> resp_valid=01 then 10; inflight_cnt returns to 0; state IDLE.
REQ-035 Scenario: 3 outstanding, flush -> state DRAIN; 3 results produce no resp_valid; req_rdy=1 gets no grant until state IDLE.
REQ-036 Scenario: result while the FIFO is empty -> tag_err=1 and stays 1, inflight_cnt stays 0; a result with the wrong tag also sets tag_err.
REQ-037 Scenario: inflight_cnt=2 with a simultaneous issue and pop -> inflight_cnt stays 2; rst in the next cycle -> all outputs 0.
REQ-038 Scenario with AGU_ARB_AGE_PRIO_EN: rob_head=30, TAG_WIDTH=5, req0 tag=2, req1 tag=31 -> grant req1.

Source files
------------

// File: rtl/agu_arbiter_if.sv
// AGU arbiter bus interface: requester offers, AGU issue/return, response routing
// and status. The master modport is the environment side, slave is the arbiter.
interface agu_arbiter_if #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned TAG_WIDTH    = 5
);
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    typedef struct packed {
        logic [TAG_WIDTH-1:0] dest_tag;
        logic [15:0]          imm;
    } instruction_t;

    typedef struct packed {
        logic                 is_valid;
        logic [TAG_WIDTH-1:0] dest_tag;
        logic [31:0]          data;
    } writeback_packet_t;

    logic                 flush;
    logic [NUM_REQ-1:0]   req_rdy;
    instruction_t         req_pkt [NUM_REQ];
    logic [NUM_REQ-1:0]   req_grant;
    logic                 agu_rdy;
    logic                 agu_valid;
    instruction_t         agu_pkt;
    writeback_packet_t    agu_port;
    logic [NUM_REQ-1:0]   resp_valid;
    writeback_packet_t    resp_pkt;
    logic [TAG_WIDTH-1:0] rob_head;
    logic [CNT_W-1:0]     inflight_cnt;
    logic                 tag_err;

    modport master (
        output flush, req_rdy, req_pkt, agu_rdy, agu_port, rob_head,
        input  req_grant, agu_valid, agu_pkt, resp_valid, resp_pkt, inflight_cnt, tag_err
    );

    modport slave (
        input  flush, req_rdy, req_pkt, agu_rdy, agu_port, rob_head,
        output req_grant, agu_valid, agu_pkt, resp_valid, resp_pkt, inflight_cnt, tag_err
    );
endinterface

// File: rtl/agu_arbiter.sv
// AGU arbiter: picks one ready reservation station per cycle, tracks ownership of
// in-order AGU results in an owner FIFO and routes each result back to its owner.
// Optional feature: define AGU_ARB_AGE_PRIO_EN to arbitrate by age relative to
// rob_head instead of round-robin.
module agu_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned TAG_WIDTH    = 5
) (
    input logic         clk,
    input logic         rst,
    agu_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

    state_e                state_q;
    logic [IDX_W-1:0]      owner_q [MAX_INFLIGHT];
    logic [TAG_WIDTH-1:0]  tag_q   [MAX_INFLIGHT];
    logic [MAX_INFLIGHT-1:0] squash_q;
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tag_err_q;

    logic                  fifo_empty, fifo_full;
    logic                  pop, stray, tag_ok, issue;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_found;

`ifdef AGU_ARB_AGE_PRIO_EN
    // Oldest-first: smallest modular distance from rob_head wins, lowest index on ties.
    always_comb begin
        logic [TAG_WIDTH-1:0] dist;
        logic [TAG_WIDTH-1:0] best;
        dist      = '0;
        best      = '1;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            dist = bus.req_pkt[IDX_W'(i)].dest_tag - bus.rob_head;
            if (bus.req_rdy[IDX_W'(i)] && (!gnt_found || dist < best)) begin
                gnt_found = 1'b1;
                best      = dist;
                gnt_idx   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q;

    // Round-robin: first ready requester at or above rr_ptr, wrapping.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (32'(rr_ptr_q) + off) % NUM_REQ;
            if (!gnt_found && bus.req_rdy[IDX_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end
`endif

    // Issue qualification, FIFO pop/error detection and combinational outputs.
    always_comb begin
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == CNT_W'(MAX_INFLIGHT));
        // A full FIFO blocks issue even if a pop frees a slot this cycle.
        issue = !rst && (state_q != StDrain) && !bus.flush && bus.agu_rdy && !fifo_full &&
                gnt_found;
        pop    = bus.agu_port.is_valid && !fifo_empty;
        stray  = bus.agu_port.is_valid && fifo_empty;
        tag_ok = (tag_q[rd_ptr_q] == bus.agu_port.dest_tag);

        bus.req_grant = issue ? (NUM_REQ'(1) << gnt_idx) : '0;
        bus.agu_valid = issue;
        bus.agu_pkt   = issue ? bus.req_pkt[gnt_idx] : '0;
        // Squashed entries (flushed or draining) and the flush cycle itself never respond.
        bus.resp_valid = (!rst && pop && tag_ok && !squash_q[rd_ptr_q] && !bus.flush) ?
                         (NUM_REQ'(1) << owner_q[rd_ptr_q]) : '0;
        bus.resp_pkt     = bus.agu_port;
        bus.inflight_cnt = cnt_q;
        bus.tag_err      = tag_err_q;

        unique case ({issue, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control FSM: flush dominates, otherwise leave BUSY/DRAIN once nothing is outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else if (bus.flush) begin
            state_q <= (cnt_d != '0) ? StDrain : StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (issue) state_q <= StBusy;
                StBusy:  if (cnt_d == '0) state_q <= StIdle;
                StDrain: if (cnt_d == '0) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Owner FIFO, occupancy counter, sticky error flag and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < MAX_INFLIGHT; k++) begin
                owner_q[k] <= '0;
                tag_q[k]   <= '0;
            end
            squash_q  <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            tag_err_q <= 1'b0;
`ifndef AGU_ARB_AGE_PRIO_EN
            rr_ptr_q  <= '0;
`endif
        end else begin
            if (issue) begin
                owner_q[wr_ptr_q]  <= gnt_idx;
                tag_q[wr_ptr_q]    <= bus.req_pkt[gnt_idx].dest_tag;
                squash_q[wr_ptr_q] <= 1'b0;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
`ifndef AGU_ARB_AGE_PRIO_EN
                rr_ptr_q <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
`endif
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            // Flush never coincides with issue, so squashing every slot is safe.
            if (bus.flush) begin
                squash_q <= '1;
            end
            cnt_q <= cnt_d;
            if (stray || (pop && !tag_ok)) begin
                tag_err_q <= 1'b1;
            end
        end
    end
endmodule
